ahb_pixel_dma_master: RTL



---
 rtl/ahb_pixel_dma_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ahb_pixel_dma_master.sv
// AHB-Lite single-word DMA master: copies cfg_word_cnt words from a source
// region into the pixel/event loader window, one read and one write per word.
module ahb_pixel_dma_master #(
    parameter int CNT_W    = 11,
    parameter int ADDR_INC = 4
) (
    input  logic             hclk,
    input  logic             hrst_b,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_src_addr,
    input  logic [31:0]      cfg_dst_addr,
    input  logic [CNT_W-1:0] cfg_word_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      m_haddr,
    output logic [1:0]       m_htrans,
    output logic             m_hwrite,
    output logic [2:0]       m_hsize,
    output logic [2:0]       m_hburst,
    output logic [31:0]      m_hwdata,
    input  logic [31:0]      m_hrdata,
    input  logic             m_hready,
    input  logic [1:0]       m_hresp
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        FIN
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [31:0] INC           = 32'(ADDR_INC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [31:0]      data;
    logic [CNT_W-1:0] remaining;
    logic             resp_err;

    assign resp_err = (m_hresp == 2'b01);
    assign m_hsize  = 3'b010;
    assign m_hburst = 3'b000;

    // Address-phase outputs are loaded on the edge that enters RD_ADDR/WR_ADDR,
    // so each state sees its bus signals already in place.
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            data      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            m_haddr   <= '0;
            m_htrans  <= HTRANS_IDLE;
            m_hwrite  <= 1'b0;
            m_hwdata  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        src       <= cfg_src_addr;
                        dst       <= cfg_dst_addr;
                        remaining <= cfg_word_cnt;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        if (cfg_word_cnt == '0) begin
                            state <= FIN;
                        end else begin
                            state    <= RD_ADDR;
                            m_htrans <= HTRANS_NONSEQ;
                            m_hwrite <= 1'b0;
                            m_haddr  <= cfg_src_addr;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_hready) begin
                        m_htrans <= HTRANS_IDLE;
                        state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_hready) begin
                        if (resp_err) begin
                            err   <= 1'b1;
                            state <= FIN;
                        end else begin
                            data     <= m_hrdata;
                            state    <= WR_ADDR;
                            m_htrans <= HTRANS_NONSEQ;
                            m_hwrite <= 1'b1;
                            m_haddr  <= dst;
                        end
                    end else if (resp_err) begin
                        err <= 1'b1;
                    end
                end
                WR_ADDR: begin
                    if (m_hready) begin
                        m_htrans <= HTRANS_IDLE;
                        m_hwdata <= data;
                        state    <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (m_hready) begin
                        if (resp_err) begin
                            err   <= 1'b1;
                            state <= FIN;
                        end else begin
                            src       <= src + INC;
                            dst       <= dst + INC;
                            remaining <= remaining - ONE;
                            if (remaining == ONE) begin
                                state <= FIN;
                            end else begin
                                state    <= RD_ADDR;
                                m_htrans <= HTRANS_NONSEQ;
                                m_hwrite <= 1'b0;
                                m_haddr  <= src + INC;
                            end
                        end
                    end else if (resp_err) begin
                        err <= 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
